// File: rtl/wb_regfile.sv
// Writeback-stage register file: x1..x(2^N-1) storage, x0 hard-wired to zero,
// two asynchronous read ports with same-cycle writeback bypass, and a 64-bit
// retired-instruction counter.
module wb_regfile #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_WIDTH-1:0]      MEM_WB_alu_out,
  input  logic [REG_WIDTH-1:0]      MEM_WB_data_out,
  input  logic [6:0]                MEM_WB_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  input  logic                      MEM_WB_reg_write_en,
  input  logic                      MEM_WB_reg_wb_sel,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
  output logic [REG_WIDTH-1:0]      ID_rdata1,
  output logic [REG_WIDTH-1:0]      ID_rdata2,
  output logic [REG_WIDTH-1:0]      wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_we,
  output logic [63:0]               instret
);

  localparam int unsigned NumRegs = (1 << REG_ADDR_WIDTH) - 1;
  localparam logic [6:0]  OpBubble = 7'h00;

  // x0 has no storage; index 0 is never written and is masked on reads
  logic [REG_WIDTH-1:0] r_regs [1:NumRegs];
  logic [63:0]          r_instret;

  logic [REG_WIDTH-1:0] w_wb_data;
  logic                 w_wb_we;
  logic [REG_WIDTH-1:0] w_rdata1;
  logic [REG_WIDTH-1:0] w_rdata2;

  // Writeback source select and effective write strobe (writes to x0 suppressed)
  always_comb begin
    w_wb_data = MEM_WB_reg_wb_sel ? MEM_WB_data_out : MEM_WB_alu_out;
    w_wb_we   = MEM_WB_reg_write_en && (MEM_WB_rd != '0);
  end

  // Register storage: async clear, write of the selected writeback value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 1; i <= NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[MEM_WB_rd] <= w_wb_data;
    end
  end

  // Retired-instruction counter; bubbles do not count, wraps silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instret <= '0;
    end else if (MEM_WB_inst_opcode != OpBubble) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  // Read port A: x0 reads zero, otherwise bypass an in-flight write to the same index
  always_comb begin
    w_rdata1 = '0;
    if (ID_rs1 != '0) begin
      if (w_wb_we && (ID_rs1 == MEM_WB_rd)) begin
        w_rdata1 = w_wb_data;
      end else begin
        w_rdata1 = r_regs[ID_rs1];
      end
    end
  end

  // Read port B: same structure as port A
  always_comb begin
    w_rdata2 = '0;
    if (ID_rs2 != '0) begin
      if (w_wb_we && (ID_rs2 == MEM_WB_rd)) begin
        w_rdata2 = w_wb_data;
      end else begin
        w_rdata2 = r_regs[ID_rs2];
      end
    end
  end

  assign ID_rdata1 = w_rdata1;
  assign ID_rdata2 = w_rdata2;
  assign wb_data   = w_wb_data;
  assign wb_rd     = MEM_WB_rd;
  assign wb_we     = w_wb_we;
  assign instret   = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected values into a queue,
// a monitor process pops and compares them against the DUT outputs.
module tb_wb_regfile;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  alu_out;
  logic [W-1:0]  data_out;
  logic [6:0]    opcode;
  logic [AW-1:0] rd;
  logic          we;
  logic          wb_sel;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [W-1:0]  rdata1;
  logic [W-1:0]  rdata2;
  logic [W-1:0]  wb_data;
  logic [AW-1:0] wb_rd;
  logic          wb_we;
  logic [63:0]   instret;

  wb_regfile #(
    .REG_WIDTH      (W),
    .REG_ADDR_WIDTH (AW)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .MEM_WB_alu_out      (alu_out),
    .MEM_WB_data_out     (data_out),
    .MEM_WB_inst_opcode  (opcode),
    .MEM_WB_rd           (rd),
    .MEM_WB_reg_write_en (we),
    .MEM_WB_reg_wb_sel   (wb_sel),
    .ID_rs1              (rs1),
    .ID_rs2              (rs2),
    .ID_rdata1           (rdata1),
    .ID_rdata2           (rdata2),
    .wb_data             (wb_data),
    .wb_rd               (wb_rd),
    .wb_we               (wb_we),
    .instret             (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {SelRd1, SelRd2, SelWbData, SelWbRd, SelWbWe, SelInstret} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [63:0] observe(sel_e s);
    case (s)
      SelRd1:     return {32'd0, rdata1};
      SelRd2:     return {32'd0, rdata2};
      SelWbData:  return {32'd0, wb_data};
      SelWbRd:    return {59'd0, wb_rd};
      SelWbWe:    return {63'd0, wb_we};
      default:    return instret;
    endcase
  endfunction

  // Monitor: on each sample strobe, drain the queue and compare
  initial begin
    exp_t e;
    logic [63:0] act;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input sel_e sel, input logic [63:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  // Let inputs settle, strobe the monitor, and wait (bounded) for it to drain
  task automatic sample();
    #1;
    ->sample_ev;
    for (int i = 0; i < 20 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic idle();
    opcode = 7'h00;
    we     = 1'b0;
    wb_sel = 1'b0;
    rd     = '0;
  endtask

  initial begin
    reset_n  = 1'b0;
    alu_out  = '0;
    data_out = '0;
    rs1      = 5'd3;
    rs2      = 5'd0;
    idle();

    // Reset state
    expect_val("reset_rdata1", SelRd1, 64'd0);
    expect_val("reset_instret", SelInstret, 64'd0);
    sample();

    @(negedge clk);
    reset_n = 1'b1;

    // Write x5 from ALU; same-cycle bypass, then read from storage
    @(negedge clk);
    rd = 5'd5; wb_sel = 1'b0; alu_out = 32'hDEAD_BEEF; we = 1'b1; opcode = 7'h33;
    rs1 = 5'd5;
    expect_val("wr5_wb_data", SelWbData, 64'hDEAD_BEEF);
    expect_val("wr5_wb_rd", SelWbRd, 64'd5);
    expect_val("wr5_wb_we", SelWbWe, 64'd1);
    expect_val("wr5_bypass", SelRd1, 64'hDEAD_BEEF);
    sample();
    @(negedge clk);
    idle(); alu_out = '0;
    expect_val("wr5_read", SelRd1, 64'hDEAD_BEEF);
    expect_val("wr5_instret", SelInstret, 64'd1);
    sample();

    // Load-data select with bypass on both ports
    rd = 5'd7; wb_sel = 1'b1; data_out = 32'h0000_1234; alu_out = 32'hFFFF_FFFF; we = 1'b1;
    rs1 = 5'd7; rs2 = 5'd7;
    expect_val("sel_bypass_rd2", SelRd2, 64'h1234);
    expect_val("sel_bypass_rd1", SelRd1, 64'h1234);
    expect_val("sel_wb_data", SelWbData, 64'h1234);
    sample();
    @(negedge clk);
    idle();
    expect_val("sel_stored_rd2", SelRd2, 64'h1234);
    expect_val("sel_stored_rd1", SelRd1, 64'h1234);
    sample();

    // Write to x0 is dropped
    rd = 5'd0; we = 1'b1; alu_out = 32'h5555_5555; rs1 = 5'd0; rs2 = 5'd0;
    expect_val("x0_wb_we", SelWbWe, 64'd0);
    expect_val("x0_rd1_same", SelRd1, 64'd0);
    expect_val("x0_rd2_same", SelRd2, 64'd0);
    sample();
    @(negedge clk);
    idle();
    expect_val("x0_rd1_next", SelRd1, 64'd0);
    expect_val("x0_rd2_next", SelRd2, 64'd0);
    sample();

    // Disabled write leaves x9 untouched and does not bypass
    rd = 5'd9; we = 1'b0; alu_out = 32'h1; rs1 = 5'd9;
    expect_val("dis_wb_we", SelWbWe, 64'd0);
    expect_val("dis_no_bypass", SelRd1, 64'd0);
    sample();
    @(negedge clk);
    idle();
    expect_val("dis_x9_stays", SelRd1, 64'd0);
    sample();

    // Instret counts non-bubble opcodes: 1 + 3 = 4
    begin
      logic [6:0] ops [5];
      ops = '{7'h33, 7'h00, 7'h23, 7'h00, 7'h63};
      for (int i = 0; i < 5; i++) begin
        opcode = ops[i];
        @(negedge clk);
      end
    end
    opcode = 7'h00;
    expect_val("instret_count", SelInstret, 64'd4);
    sample();

    // Write x3, then pulse reset mid-cycle
    rd = 5'd3; wb_sel = 1'b0; alu_out = 32'hA5A5_A5A5; we = 1'b1;
    @(negedge clk);
    idle();
    rs1 = 5'd3; rs2 = 5'd7;
    expect_val("pre_rst_x3", SelRd1, 64'hA5A5_A5A5);
    expect_val("pre_rst_instret", SelInstret, 64'd4);
    sample();
    #1;
    reset_n = 1'b0;
    expect_val("rst_x3_cleared", SelRd1, 64'd0);
    expect_val("rst_x7_cleared", SelRd2, 64'd0);
    expect_val("rst_instret", SelInstret, 64'd0);
    sample();

    // While held in reset: bypass still works, writes and counting blocked
    rd = 5'd4; we = 1'b1; alu_out = 32'h77; opcode = 7'h33; rs2 = 5'd4;
    expect_val("rst_bypass", SelRd2, 64'h77);
    sample();
    @(negedge clk);
    idle();
    expect_val("rst_no_write", SelRd2, 64'd0);
    expect_val("rst_no_count", SelInstret, 64'd0);
    sample();
    reset_n = 1'b1;

    // First edge after release counts normally
    opcode = 7'h33;
    @(negedge clk);
    opcode = 7'h00;
    expect_val("post_rst_instret", SelInstret, 64'd1);
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameters: REG_WIDTH, default 32, data width; REG_ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- MEM_WB_alu_out  in  REG_WIDTH  ALU result from MEM/WB.
- MEM_WB_data_out  in  REG_WIDTH  DMEM load data from MEM/WB.
- MEM_WB_inst_opcode  in  7  retiring opcode; 7'h00 marks a bubble.
- MEM_WB_rd  in  REG_ADDR_WIDTH  destination index.
- MEM_WB_reg_write_en  in  1  writeback enable.
- MEM_WB_reg_wb_sel  in  1  source select: 1 selects load data, 0 selects ALU.
- ID_rs1  in  REG_ADDR_WIDTH  decode read index A.
- ID_rs2  in  REG_ADDR_WIDTH  decode read index B.
- ID_rdata1  out  REG_WIDTH  read data A.
- ID_rdata2  out  REG_WIDTH  read data B.
- wb_data  out  REG_WIDTH  selected writeback value, for forwarding.
- wb_rd  out  REG_ADDR_WIDTH  writeback index, for forwarding.
- wb_we  out  1  effective write strobe.
- instret  out  64  retired-instruction counter.

Function
REQ-003 SHALL drive wb_data combinationally as MEM_WB_data_out when MEM_WB_reg_wb_sel=1, else MEM_WB_alu_out.
REQ-004 SHALL drive wb_rd = MEM_WB_rd and wb_we = MEM_WB_reg_write_en AND (MEM_WB_rd != 0), both combinationally.
REQ-005 SHALL hold 2^REG_ADDR_WIDTH - 1 storage registers, x1 upward.
- x0 has no storage and always reads 0.
REQ-006 SHALL write wb_data into register MEM_WB_rd on the rising clk edge when wb_we=1.
- Written value is visible on the read ports in the following cycle.
REQ-007 SHALL ignore writes to x0 with no side effect.
REQ-008 SHALL provide combinational (asynchronous) reads on both ports; ID_rdata1 and ID_rdata2 depend only on the index, storage and bypass state.
REQ-009 SHALL bypass each read port when wb_we=1 and ID_rsN == MEM_WB_rd != 0: that port returns wb_data in the same cycle.
REQ-010 SHALL return 0 on a port whose index is 0, regardless of any write or bypass condition.
REQ-011 SHALL let both read ports address the same register, or the same bypassed register, simultaneously and return identical data.
REQ-012 SHALL increment instret by 1 on each rising clk edge where MEM_WB_inst_opcode != 7'h00, independent of MEM_WB_reg_write_en.
- Stores and branches also count.
REQ-013 SHALL wrap instret from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-014 SHALL NOT increment instret for bubble opcodes (7'h00).
REQ-015 SHALL add no pipeline latency: write takes effect at 1 edge, bypass at 0 cycles, instret at 1 edge.

Reset
REQ-016 SHALL, while reset_n=0, asynchronously clear all storage registers to 0 and instret to 0.
REQ-017 SHALL block writes and instret counting while reset_n=0.
- Combinational outputs still follow their inputs.
- Reads return 0 unless bypassed.
REQ-018 SHALL discard the state of any in-flight writeback cycle when reset is asserted mid-operation.
- First edge after deassertion behaves per REQ-006 and REQ-012.

Verification
REQ-019 SHALL pass these directed scenarios:
- Write: rd=5, wb_sel=0, alu_out=32'hDEADBEEF, we=1, one edge -> next cycle, rs1=5 gives ID_rdata1=32'hDEADBEEF.
- Select and bypass: rd=7, wb_sel=1, data_out=32'h0000_1234, alu_out=32'hFFFF_FFFF, we=1, rs2=7, same cycle -> ID_rdata2=32'h0000_1234, wb_data=32'h0000_1234.
- x0: rd=0, we=1, alu_out=32'h5555_5555 -> wb_we=0; rs1=rs2=0 gives 0 in the same and next cycles.
- Disabled write: rd=9, we=0, alu_out=32'h1 -> x9 stays 0; no bypass on rs1=9.
- instret: opcodes 7'h33, 7'h00, 7'h23, 7'h00, 7'h63 over 5 edges -> instret=3.
- Reset: after x3=32'hA5A5_A5A5 and instret=4, pulse reset_n low mid-cycle -> immediately x3 reads 0 and instret=0; first edge after release resumes counting.
